// File: rtl/slc3_pkg.sv
// slc3_pkg: state encoding, opcodes and mux-select codes for the SLC-3 controller
package slc3_pkg;

    typedef enum logic [3:0] {
        S_HALTED,
        S_FETCH1,
        S_FETCH2,
        S_FETCH3,
        S_DECODE,
        S_LDR1,
        S_LDR2,
        S_LDR3,
        S_STR1,
        S_STR2,
        S_STR3,
        S_PAUSE1,
        S_PAUSE2
    } state_t;

    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_PSE = 4'b1101;

    localparam logic [1:0] PCMUX_PLUS1 = 2'd0;
    localparam logic [1:0] DRMUX_MEM   = 2'd0;
    localparam logic [1:0] DRMUX_SR    = 2'd1;
    localparam logic       MARMUX_PC   = 1'b0;
    localparam logic       MARMUX_ADDR = 1'b1;

endpackage

// File: rtl/slc3_control.sv
// slc3_control: fetch/LDR/STR/PAUSE sequencer driving SLC-3 datapath enables and memory handshake
module slc3_control
    import slc3_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic        cont,
    input  logic [15:0] ir,
    input  logic        mem_resp,
    output logic        ld_pc,
    output logic        ld_mar,
    output logic        ld_mdr,
    output logic        ld_ir,
    output logic        ld_reg,
    output logic        ld_cc,
    output logic [1:0]  pcmux,
    output logic [1:0]  drmux,
    output logic        marmux,
    output logic        mem_read,
    output logic        mem_write,
    output logic        halted,
    output logic        paused
);

    state_t state_q, state_d;

    // Only the opcode field steers sequencing; operand bits belong to the datapath.
    logic ir_operand_unused;
    assign ir_operand_unused = ^ir[11:0];

    // State register; reset abandons any in-flight memory request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_HALTED;
        else          state_q <= state_d;
    end

    // Next state and Moore outputs, with ld_mdr qualified by mem_resp in the read-wait states.
    always_comb begin
        state_d   = state_q;
        ld_pc     = 1'b0;
        ld_mar    = 1'b0;
        ld_mdr    = 1'b0;
        ld_ir     = 1'b0;
        ld_reg    = 1'b0;
        ld_cc     = 1'b0;
        pcmux     = PCMUX_PLUS1;
        drmux     = DRMUX_MEM;
        marmux    = MARMUX_PC;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        halted    = 1'b0;
        paused    = 1'b0;
        case (state_q)
            S_HALTED: begin
                halted  = 1'b1;
                state_d = run ? S_FETCH1 : S_HALTED;
            end
            S_FETCH1: begin
                ld_mar  = 1'b1;
                marmux  = MARMUX_PC;
                ld_pc   = 1'b1;
                pcmux   = PCMUX_PLUS1;
                state_d = S_FETCH2;
            end
            S_FETCH2: begin
                mem_read = 1'b1;
                drmux    = DRMUX_MEM;
                ld_mdr   = mem_resp;
                state_d  = mem_resp ? S_FETCH3 : S_FETCH2;
            end
            S_FETCH3: begin
                ld_ir   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = (ir[15:12] == OP_LDR) ? S_LDR1 :
                          (ir[15:12] == OP_STR) ? S_STR1 :
                          (ir[15:12] == OP_PSE) ? S_PAUSE1 : S_FETCH1;
            end
            S_LDR1: begin
                ld_mar  = 1'b1;
                marmux  = MARMUX_ADDR;
                state_d = S_LDR2;
            end
            S_LDR2: begin
                mem_read = 1'b1;
                drmux    = DRMUX_MEM;
                ld_mdr   = mem_resp;
                state_d  = mem_resp ? S_LDR3 : S_LDR2;
            end
            S_LDR3: begin
                ld_reg  = 1'b1;
                ld_cc   = 1'b1;
                state_d = S_FETCH1;
            end
            S_STR1: begin
                ld_mar  = 1'b1;
                marmux  = MARMUX_ADDR;
                state_d = S_STR2;
            end
            S_STR2: begin
                ld_mdr  = 1'b1;
                drmux   = DRMUX_SR;
                state_d = S_STR3;
            end
            S_STR3: begin
                mem_write = 1'b1;
                state_d   = mem_resp ? S_FETCH1 : S_STR3;
            end
            S_PAUSE1: begin
                paused  = 1'b1;
                state_d = cont ? S_PAUSE2 : S_PAUSE1;
            end
            S_PAUSE2: begin
                paused  = 1'b1;
                state_d = cont ? S_PAUSE2 : S_FETCH1;
            end
            default: state_d = S_HALTED;
        endcase
    end

endmodule
